// File: rtl/guess_entry_controller.sv
// Keypad guess entry: collects four hex digits, offers them downstream, scans a 4-digit display.
// Optional macro BLANK_UNUSED_DIGITS_EN blanks display positions with no entered digit.
module guess_entry_controller #(
    parameter int SCAN_BITS = 18
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        guess_valid,
    input  logic        guess_ready,
    output logic [15:0] guess_value,
    output logic [2:0]  digit_count,
    output logic [3:0]  anode,
    output logic [3:0]  hex_out
);

    localparam logic [1:0] ENTRY  = 2'd0;
    localparam logic [1:0] FULL   = 2'd1;
    localparam logic [1:0] SUBMIT = 2'd2;
    localparam int SW = SCAN_BITS + 2;

    logic [1:0]    state, state_nx;
    logic [15:0]   buffer, buffer_nx;
    logic [2:0]    count, count_nx;
    logic [SW-1:0] scan;
    logic [1:0]    phase;
    logic          is_digit, is_bs, is_clr, is_ent;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_bs    = key_valid && (key_code == 4'hA);
    assign is_clr   = key_valid && (key_code == 4'hC);
    assign is_ent   = key_valid && (key_code == 4'hE);

    always_comb begin
        state_nx  = state;
        buffer_nx = buffer;
        count_nx  = count;
        if (state == SUBMIT) begin
            if (guess_ready) begin
                state_nx  = ENTRY;
                buffer_nx = 16'h0000;
                count_nx  = 3'd0;
            end
        end else begin
            unique case (1'b1)
                is_digit: begin
                    if (state == ENTRY) begin
                        buffer_nx = {buffer[11:0], key_code};
                        count_nx  = count + 3'd1;
                        if (count == 3'd3) state_nx = FULL;
                    end
                end
                is_bs: begin
                    if (count != 3'd0) begin
                        buffer_nx = {4'h0, buffer[15:4]};
                        count_nx  = count - 3'd1;
                        state_nx  = ENTRY;
                    end
                end
                is_clr: begin
                    buffer_nx = 16'h0000;
                    count_nx  = 3'd0;
                    state_nx  = ENTRY;
                end
                is_ent: begin
                    if (state == FULL) state_nx = SUBMIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ENTRY;
            buffer <= 16'h0000;
            count  <= 3'd0;
        end else begin
            state  <= state_nx;
            buffer <= buffer_nx;
            count  <= count_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) scan <= '0;
        else          scan <= scan + 1'b1;
    end

    assign phase       = scan[SW-1 -: 2];
    // Valid is decoded from state so an async reset drops it at once.
    assign guess_valid = (state == SUBMIT);
    assign guess_value = buffer;
    assign digit_count = count;

    always_comb begin
        anode   = ~(4'b0001 << phase);
        hex_out = buffer[{phase, 2'b00} +: 4];
`ifdef BLANK_UNUSED_DIGITS_EN
        if ({1'b0, phase} >= count) begin
            anode   = 4'b1111;
            hex_out = 4'h0;
        end
`else
`endif
    end

endmodule
